alu32_seq_driver: RTL and testbench
===================================

# alu32_seq_driver

Sequential initiator that sits in front of the 16-bit 74181/74182 ALU datapath and executes 32-bit operations as two chained 16-bit passes. It accepts commands over a valid/ready handshake, drives the ALU's operand, select, mode and carry pins for a low pass then a high pass, and captures each 16-bit result. The low-pass carry feeds the high pass. The 32-bit result and flags are returned over a second valid/ready handshake.

## Interface
- DATA_W, 32, command/response width; only 32 is supported (two 16-bit passes)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver can accept; high only in IDLE
- cmd_op  in  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOTA, 110 ADC, 111 reserved
- cmd_a, cmd_b  in  32  operands
- cmd_cin  in  1  active-high carry-in, used by ADC only
- alu_a, alu_b  out  16  ALU operand pins, active-high data convention
- alu_sel  out  4  ALU select pins
- alu_mode  out  1  ALU mode pin; 1 = logic
- alu_cin  out  1  ALU carry-in pin; active-low carry, so 1 = no carry
- alu_result  in  16  ALU function output, combinational from the alu_* pins
- alu_cout  in  1  ALU carry-out pin; active-low carry
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  result
- rsp_carry  out  1  active-high carry (ADD/ADC) or no-borrow (SUB); 0 for logic ops
- rsp_zero  out  1  rsp_result == 0
- rsp_err  out  1  reserved opcode

## Operation
- FSM states: IDLE, LO, HI, RESP.
- IDLE: when cmd_valid is high, the command fires.
  - A valid opcode latches operands, op and cin, then moves to LO.
  - Opcode 111 moves directly to RESP with rsp_result=0, rsp_err=1, rsp_carry=0, rsp_zero=1.
- Decode (op → sel, mode, low-pass alu_cin):
  - ADD: 1001, 0, 1
  - ADC: 1001, 0, ~cin
  - SUB: 0110, 0, 0 (gives A−B)
  - AND: 1011, 1, 1
  - OR: 1110, 1, 1
  - XOR: 0110, 1, 1
  - NOTA: 0000, 1, 1
- LO: drive alu_a/alu_b = operand[15:0] with the decoded sel, mode and cin. At the clock edge:
  - capture alu_result into result[15:0];
  - capture alu_cout raw into the chain register;
  - go to HI.
- HI: drive operand[31:16] and the same sel/mode. alu_cin is the raw captured chain bit; it passes through unchanged, with no inversion, because both ends use active-low carry. At the clock edge:
  - capture alu_result into result[31:16];
  - set rsp_carry = ~alu_cout for arithmetic ops, 0 for logic ops;
  - compute rsp_zero from the full 32-bit result;
  - go to RESP.
- RESP: hold rsp_valid high and all rsp_* outputs stable until rsp_ready is high, then go to IDLE.
- Outside LO/HI: alu_a = alu_b = 0, alu_sel = 0, alu_mode = 1, alu_cin = 1.

## Timing
- Reset values: state IDLE, cmd_ready 1, rsp_valid 0, all rsp_* 0, alu_a/alu_b/alu_sel 0, alu_mode 1, alu_cin 1.
- All outputs are registered or decoded from registered state only; there is no combinational path from cmd_* or rsp_ready to any output.
- Latency: handshake at edge N → LO during cycle N+1 → HI during N+2 → rsp_valid high from N+3.
  - Reserved opcode: rsp_valid high from N+1.
- Back-to-back: cmd_ready returns high the cycle after the rsp handshake, so a new command needs at least 4 cycles.
- cmd_valid while not in IDLE is ignored; cmd_ready is low, so nothing is lost.
- rsp_ready held high before rsp_valid: response completes in its first RESP cycle.
- The ALU path is combinational and must settle within one clk period.
- rst high in any state:
  - next state is IDLE;
  - any in-flight command is dropped and no response is produced;
  - rsp_valid is cleared even if a response was pending.

## Structure
- Package alu_drv_pkg holds:
  - the opcode localparams (OP_ADD … OP_RSVD);
  - the sel encodings (SEL_ADD=1001, SEL_SUB=0110, SEL_AND=1011, SEL_OR=1110, SEL_XOR=0110, SEL_NOTA=0000);
  - the FSM state encoding.
- One combinational sub-module, alu_op_decode: inputs op and cin; outputs sel, mode, lo_cin, is_arith, is_rsvd.
- The FSM, operand/result registers and carry chain register live in alu32_seq_driver.

## Test plan
- ADD a=0x0001FFFF, b=0x00000001 → LO drives alu_cin=1 and sees alu_cout=0 → HI drives alu_cin=0 → rsp_result=0x00020000, rsp_carry=0, rsp_zero=0, at cycle N+3.
- ADD a=0xFFFFFFFF, b=0x00000001 → rsp_result=0x00000000, rsp_carry=1, rsp_zero=1. ADC with cin=1, a=b=0 → rsp_result=0x00000001.
- SUB a=0x00010000, b=0x00000001 → rsp_result=0x0000FFFF, rsp_carry=1 (no borrow). SUB a=0, b=1 → rsp_result=0xFFFFFFFF, rsp_carry=0.
- Logic ops with a=0xF0F0AAAA, b=0xFF005555, each checked as a separate command:
  - AND → 0xF0000000;
  - OR → 0xFFF0FFFF;
  - XOR → 0x0FF0FFFF;
  - NOTA → 0x0F0F5555;
  - rsp_carry=0 for all.
- Backpressure and sequencing:
  - hold rsp_ready=0 for 5 cycles → rsp_* stable, cmd_ready=0;
  - cmd_valid pulses during busy cycles are ignored;
  - opcode 111 → rsp_err=1, rsp_result=0, at N+1.
- Reset mid-op: assert rst during HI → next cycle IDLE, rsp_valid=0, all alu_* at reset values, and no response ever appears for that command.

Source files
------------

// File: rtl/alu_drv_pkg.sv
// alu_drv_pkg: opcodes, 74181 select encodings and FSM state encoding for alu32_seq_driver
package alu_drv_pkg;
    localparam int HALF_W = 16;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOTA = 3'b101;
    localparam logic [2:0] OP_ADC  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;
    localparam logic [3:0] SEL_ADD  = 4'b1001;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_AND  = 4'b1011;
    localparam logic [3:0] SEL_OR   = 4'b1110;
    localparam logic [3:0] SEL_XOR  = 4'b0110;
    localparam logic [3:0] SEL_NOTA = 4'b0000;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;
endpackage

// File: rtl/alu32_seq_driver_decode.sv
// alu_op_decode: maps an opcode to 74181 select/mode pins and the low-pass carry-in
//   op, cin         : opcode and active-high carry-in (ADC only)
//   sel, mode       : ALU select and mode pins (mode 1 = logic)
//   lo_cin          : active-low carry-in for the low pass
//   is_arith        : ADD/SUB/ADC, produce a carry flag
//   is_rsvd         : reserved opcode
module alu_op_decode
    import alu_drv_pkg::*;
(
    input  logic [2:0] op,
    input  logic       cin,
    output logic [3:0] sel,
    output logic       mode,
    output logic       lo_cin,
    output logic       is_arith,
    output logic       is_rsvd
);
    assign sel = (op == OP_ADD || op == OP_ADC) ? SEL_ADD :
                 op == OP_SUB ? SEL_SUB :
                 op == OP_AND ? SEL_AND :
                 op == OP_OR  ? SEL_OR  :
                 op == OP_XOR ? SEL_XOR : SEL_NOTA;
    assign is_arith = op == OP_ADD || op == OP_SUB || op == OP_ADC;
    assign mode     = ~is_arith;
    // SUB forces a low-pass carry so the 74181's A-B-1 becomes A-B
    assign lo_cin   = op == OP_ADC ? ~cin : op != OP_SUB;
    assign is_rsvd  = op == OP_RSVD;
endmodule

// File: rtl/alu32_seq_driver.sv
// alu32_seq_driver: runs 32-bit ops as two chained 16-bit passes on a 74181/74182 ALU
//   cmd_*      : command valid/ready handshake with opcode, operands and carry-in
//   alu_*      : ALU pins (active-high data, active-low carries); alu_result/alu_cout return
//   rsp_*      : response valid/ready handshake with result, carry, zero and error flags
module alu32_seq_driver
    import alu_drv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_cin,
    output logic [HALF_W-1:0] alu_a,
    output logic [HALF_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    output logic              alu_mode,
    output logic              alu_cin,
    input  logic [HALF_W-1:0] alu_result,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              rsp_err
);
    logic [1:0]        state;
    logic [DATA_W-1:0] a_q, b_q;
    logic [2:0]        op_q;
    logic              cin_q, chain;
    logic [2:0]        dec_op;
    logic              dec_cin;
    logic [3:0]        sel;
    logic              mode, lo_cin, is_arith, is_rsvd;
    logic              lo, hi;
    // in IDLE the decoder looks at the incoming opcode (only is_rsvd is used there);
    // otherwise it decodes the latched command that drives the ALU pins
    assign dec_op  = state == ST_IDLE ? cmd_op : op_q;
    assign dec_cin = state == ST_IDLE ? cmd_cin : cin_q;
    alu_op_decode u_dec (
        .op       (dec_op),
        .cin      (dec_cin),
        .sel      (sel),
        .mode     (mode),
        .lo_cin   (lo_cin),
        .is_arith (is_arith),
        .is_rsvd  (is_rsvd)
    );
    assign lo        = state == ST_LO;
    assign hi        = state == ST_HI;
    assign cmd_ready = state == ST_IDLE;
    assign rsp_valid = state == ST_RESP;
    assign alu_a     = lo ? a_q[HALF_W-1:0] : hi ? a_q[2*HALF_W-1:HALF_W] : '0;
    assign alu_b     = lo ? b_q[HALF_W-1:0] : hi ? b_q[2*HALF_W-1:HALF_W] : '0;
    assign alu_sel   = (lo || hi) ? sel : '0;
    assign alu_mode  = (lo || hi) ? mode : 1'b1;
    // both carry ends are active-low, so the captured chain bit feeds HI unchanged
    assign alu_cin   = lo ? lo_cin : hi ? chain : 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            cin_q      <= 1'b0;
            chain      <= 1'b1;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    if (is_rsvd) begin
                        rsp_result <= '0;
                        rsp_carry  <= 1'b0;
                        rsp_zero   <= 1'b1;
                        rsp_err    <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        op_q    <= cmd_op;
                        cin_q   <= cmd_cin;
                        rsp_err <= 1'b0;
                        state   <= ST_LO;
                    end
                end
                ST_LO: begin
                    rsp_result[HALF_W-1:0] <= alu_result;
                    chain                  <= alu_cout;
                    state                  <= ST_HI;
                end
                ST_HI: begin
                    rsp_result[2*HALF_W-1:HALF_W] <= alu_result;
                    rsp_carry <= is_arith & ~alu_cout;
                    rsp_zero  <= {alu_result, rsp_result[HALF_W-1:0]} == '0;
                    state     <= ST_RESP;
                end
                default: if (rsp_ready) state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu32_seq_driver.sv
// tb_alu32_seq_driver: scoreboard bench with a behavioural 74181 model on the ALU pins
module tb_alu32_seq_driver;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010, OR = 3'b011;
    localparam logic [2:0] XOR = 3'b100, NOTA = 3'b101, ADC = 3'b110, RSVD = 3'b111;
    typedef struct {
        logic [31:0] r;
        logic        c, z, e;
    } exp_t;
    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_ready, cmd_cin = 0;
    logic [2:0]  cmd_op = 0;
    logic [31:0] cmd_a = 0, cmd_b = 0;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;
    logic        alu_mode, alu_cin, alu_cout;
    logic        rsp_valid, rsp_ready = 0, rsp_carry, rsp_zero, rsp_err;
    logic [31:0] rsp_result;
    logic [16:0] alu_sum;
    always #5 clk = ~clk;
    alu32_seq_driver dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_mode(alu_mode),
        .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );
    // 74181, active-high data: S=1001 is A plus B, S=0110 is A minus B minus 1, carries active-low
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_sel == 4'b1001 ? alu_b : ~alu_b} + {16'b0, ~alu_cin};
    always_comb begin
        alu_result = alu_sum[15:0];
        alu_cout   = ~alu_sum[16];
        if (alu_mode) begin
            alu_cout   = 1'b1;
            alu_result = alu_sel == 4'b1011 ? alu_a & alu_b :
                         alu_sel == 4'b1110 ? alu_a | alu_b :
                         alu_sel == 4'b0110 ? alu_a ^ alu_b :
                         alu_sel == 4'b0000 ? ~alu_a : 16'h0;
        end
    end
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, b, input logic cin);
        exp_t e;
        e.c = 0;
        e.e = 0;
        case (op)
            ADD:     {e.c, e.r} = {1'b0, a} + {1'b0, b};
            ADC:     {e.c, e.r} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
            SUB:     begin e.r = a - b; e.c = a >= b; end
            AND:     e.r = a & b;
            OR:      e.r = a | b;
            XOR:     e.r = a ^ b;
            NOTA:    e.r = ~a;
            default: begin e.r = 0; e.e = 1; end
        endcase
        e.z = e.r == 0;
        return e;
    endfunction
    function automatic logic [3:0] exp_sel(input logic [2:0] op);
        return (op == ADD || op == ADC) ? 4'b1001 : op == SUB ? 4'b0110 : op == AND ? 4'b1011 :
               op == OR ? 4'b1110 : op == XOR ? 4'b0110 : 4'b0000;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask
    task automatic send(input logic [2:0] op, input logic [31:0] a, b, input logic cin);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_wait", {31'b0, cmd_ready}, 1);
        cmd_valid = 1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        sb.push_back(model(op, a, b, cin));
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask
    task automatic run(input logic [2:0] op, input logic [31:0] a, b, input logic cin,
                       input int stall, input logic pre_ready);
        exp_t e;
        int lat = 1;
        logic lo_cout = 1;
        rsp_ready = pre_ready;
        send(op, a, b, cin);
        if (stall > 0) begin
            cmd_valid = 1;
            cmd_op    = ADD;
            cmd_a     = $urandom;
            cmd_b     = $urandom;
        end
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            if (lat == 1) begin
                chk("lo_alu_a", {16'b0, alu_a}, {16'b0, a[15:0]});
                chk("lo_alu_b", {16'b0, alu_b}, {16'b0, b[15:0]});
                chk("lo_alu_sel", {28'b0, alu_sel}, {28'b0, exp_sel(op)});
                chk("lo_alu_mode", {31'b0, alu_mode}, {31'b0, !(op == ADD || op == SUB || op == ADC)});
                chk("lo_alu_cin", {31'b0, alu_cin}, {31'b0, op == ADC ? ~cin : op != SUB});
                lo_cout = alu_cout;
            end
            if (lat == 2) begin
                chk("hi_alu_a", {16'b0, alu_a}, {16'b0, a[31:16]});
                chk("hi_alu_b", {16'b0, alu_b}, {16'b0, b[31:16]});
                chk("hi_alu_sel", {28'b0, alu_sel}, {28'b0, exp_sel(op)});
                chk("hi_alu_cin", {31'b0, alu_cin}, {31'b0, lo_cout});
            end
            if (stall > 0) chk("busy_cmd_ready", {31'b0, cmd_ready}, 0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), op == RSVD ? 1 : 3);
        e = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            chk("stall_result", rsp_result, e.r);
            chk("stall_valid", {31'b0, rsp_valid}, 1);
            chk("stall_cmd_ready", {31'b0, cmd_ready}, 0);
            @(negedge clk);
        end
        cmd_valid = 0;
        chk("rsp_result", rsp_result, e.r);
        chk("rsp_carry", {31'b0, rsp_carry}, {31'b0, e.c});
        chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, e.z});
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.e});
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        @(negedge clk);
        chk("post_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("post_rsp_valid", {31'b0, rsp_valid}, 0);
    endtask
    initial begin
        int seen = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_flags", {28'b0, rsp_carry, rsp_zero, rsp_err, 1'b0}, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_alu_pins", {alu_a, alu_b}, 0);
        chk("rst_alu_ctl", {26'b0, alu_sel, alu_mode, alu_cin}, 32'h3);
        run(ADD, 32'h0001FFFF, 32'h00000001, 0, 0, 0);
        run(ADD, 32'hFFFFFFFF, 32'h00000001, 0, 0, 1);
        run(ADC, 32'h0, 32'h0, 1, 0, 0);
        run(ADC, 32'h1234FFFF, 32'h00010000, 0, 0, 0);
        run(SUB, 32'h00010000, 32'h00000001, 0, 0, 0);
        run(SUB, 32'h0, 32'h1, 0, 0, 0);
        run(AND, 32'hF0F0AAAA, 32'hFF005555, 0, 0, 0);
        run(OR, 32'hF0F0AAAA, 32'hFF005555, 0, 0, 0);
        run(XOR, 32'hF0F0AAAA, 32'hFF005555, 0, 0, 0);
        run(NOTA, 32'hF0F0AAAA, 32'hFF005555, 0, 0, 0);
        run(ADD, 32'h89ABCDEF, 32'h76543210, 0, 5, 0);
        run(RSVD, 32'h12345678, 32'h9ABCDEF0, 1, 0, 0);
        run(RSVD, 32'h1, 32'h1, 0, 2, 0);
        run(SUB, 32'h80000000, 32'h7FFFFFFF, 0, 0, 1);
        send(ADD, 32'h00030001, 32'h00020002, 0);
        sb.delete(sb.size() - 1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_hi_alu_a", {16'b0, alu_a}, 32'h3);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("mid_rst_alu_pins", {alu_a, alu_b}, 0);
        chk("mid_rst_alu_ctl", {26'b0, alu_sel, alu_mode, alu_cin}, 32'h3);
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        chk("no_rsp_after_rst", 32'(seen), 0);
        run(ADD, 32'h00000005, 32'h00000007, 0, 0, 0);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
